// File: rtl/risc_core_pipe.sv
// Two-stage (fetch / execute-writeback) 16-bit LOAD/STORE/MOVE/MAC core with
// start/halt run control, branch-with-flush, persistent MAC accumulator and debug read port.
module risc_core_pipe #(
  parameter int unsigned ISA_WIDTH       = 16,
  parameter int unsigned REG_DATA_WIDTH  = 16,
  parameter int unsigned REG_ADDR_WIDTH  = 4,
  parameter int unsigned MEM_ADDR_WIDTH  = 5,
  parameter int unsigned IMEM_ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_wen,
  input  logic [IMEM_ADDR_WIDTH-1:0] inst_addr,
  input  logic [ISA_WIDTH-1:0]       input_inst,
  input  logic                       start,
  input  logic [REG_ADDR_WIDTH-1:0]  dbg_addr,
  output logic [REG_DATA_WIDTH-1:0]  dbg_data,
  output logic                       busy,
  output logic                       halted,
  output logic [IMEM_ADDR_WIDTH-1:0] pc,
  output logic [CNT_WIDTH-1:0]       retired
);

  localparam int NumRegs  = 2 ** REG_ADDR_WIDTH;
  localparam int DmemSize = 2 ** MEM_ADDR_WIDTH;
  localparam int ImemSize = 2 ** IMEM_ADDR_WIDTH;

  localparam logic [2:0] OpLoad  = 3'b000;
  localparam logic [2:0] OpStore = 3'b001;
  localparam logic [2:0] OpMove  = 3'b010;
  localparam logic [2:0] OpMac   = 3'b011;
  localparam logic [2:0] OpBnz   = 3'b100;
  localparam logic [2:0] OpHalt  = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e                      r_state, w_state_d;
  logic [IMEM_ADDR_WIDTH-1:0]  r_pc, w_pc_d;
  logic [ISA_WIDTH-1:0]        r_ir, w_ir_d;
  logic [IMEM_ADDR_WIDTH-1:0]  r_ir_pc, w_ir_pc_d;
  logic                        r_ir_valid, w_ir_valid_d;
  logic [CNT_WIDTH-1:0]        r_retired, w_retired_d;
  logic [REG_DATA_WIDTH-1:0]   r_acc;

  logic [ISA_WIDTH-1:0]        r_imem [ImemSize];
  logic [REG_DATA_WIDTH-1:0]   r_dmem [DmemSize];
  logic [REG_DATA_WIDTH-1:0]   r_regs [NumRegs];

  logic [2:0]                  w_op;
  logic [REG_ADDR_WIDTH-1:0]   w_rd, w_rs1, w_rs2;
  logic [4:0]                  w_imm5;
  logic [8:0]                  w_imm9;
  logic                        w_funct;
  logic [REG_DATA_WIDTH-1:0]   w_rd_val, w_rs1_val, w_rs2_val;
  logic [REG_DATA_WIDTH-1:0]   w_prod, w_mac;
  logic [MEM_ADDR_WIDTH-1:0]   w_ld_addr, w_st_addr;
  logic [IMEM_ADDR_WIDTH-1:0]  w_target;
  logic                        w_ex_valid, w_ex_halt, w_br_taken;

  // Decode of the instruction sitting in the EX stage
  assign w_op      = r_ir[15:13];
  assign w_rd      = REG_ADDR_WIDTH'(r_ir[12:9]);
  assign w_rs1     = REG_ADDR_WIDTH'(r_ir[8:5]);
  assign w_rs2     = REG_ADDR_WIDTH'(r_ir[4:1]);
  assign w_funct   = r_ir[0];
  assign w_imm5    = r_ir[4:0];
  assign w_imm9    = r_ir[8:0];

  assign w_rd_val  = r_regs[w_rd];
  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];

  assign w_prod    = w_rs1_val * w_rs2_val;
  assign w_mac     = w_funct ? (r_acc + w_prod) : w_prod;
  assign w_ld_addr = MEM_ADDR_WIDTH'(w_rs1_val + REG_DATA_WIDTH'(w_imm5));
  assign w_st_addr = w_rs1_val[MEM_ADDR_WIDTH-1:0];
  assign w_target  = r_ir_pc + IMEM_ADDR_WIDTH'($signed(w_imm9));

  assign w_ex_valid = r_ir_valid && (r_state == StRun);
  assign w_ex_halt  = w_ex_valid && (w_op == OpHalt);
  assign w_br_taken = w_ex_valid && (w_op == OpBnz) && (w_rd_val != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_ir       <= w_ir_d;
      r_ir_pc    <= w_ir_pc_d;
      r_ir_valid <= w_ir_valid_d;
      r_retired  <= w_retired_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_ir_d       = r_ir;
    w_ir_pc_d    = r_ir_pc;
    w_ir_valid_d = r_ir_valid;
    w_retired_d  = r_retired;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d    = StRun;
          w_pc_d       = '0;
          w_ir_valid_d = 1'b0;
        end
      end
      StRun: begin
        w_ir_d       = r_imem[r_pc];
        w_ir_pc_d    = r_pc;
        w_ir_valid_d = 1'b1;
        w_pc_d       = r_pc + IMEM_ADDR_WIDTH'(1);
        if (w_ex_valid && (w_op != OpHalt)) begin
          w_retired_d = r_retired + CNT_WIDTH'(1);
        end
        // HALT discards the fetched successor and freezes pc on the address after it
        if (w_ex_halt) begin
          w_state_d    = StHalted;
          w_ir_valid_d = 1'b0;
          w_pc_d       = r_pc;
        end else if (w_br_taken) begin
          w_pc_d       = w_target;
          w_ir_valid_d = 1'b0;
        end
      end
      StHalted: begin
        if (start) begin
          w_state_d    = StRun;
          w_pc_d       = '0;
          w_ir_valid_d = 1'b0;
          w_retired_d  = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
      r_acc <= '0;
    end else if (w_ex_valid) begin
      case (w_op)
        OpLoad:  r_regs[w_rd] <= r_dmem[w_ld_addr];
        OpMove:  r_regs[w_rd] <= REG_DATA_WIDTH'(w_imm9);
        OpMac: begin
          r_regs[w_rd] <= w_mac;
          r_acc        <= w_mac;
        end
        default: ;
      endcase
    end
  end

  // Memories are never cleared; the guard on rst keeps an aborted run from writing
  always_ff @(posedge clk) begin
    if (!rst && w_ex_valid && (w_op == OpStore)) begin
      r_dmem[w_st_addr] <= w_rs2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && inst_wen && (r_state != StRun)) begin
      r_imem[inst_addr] <= input_inst;
    end
  end

  assign dbg_data = r_regs[dbg_addr];
  assign busy     = (r_state == StRun);
  assign halted   = (r_state == StHalted);
  assign pc       = r_pc;
  assign retired  = r_retired;

endmodule

// File: tb/tb_risc_core_pipe.sv
// Directed bench for risc_core_pipe: hand-assembled programs with hand-computed results.
module tb_risc_core_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_wen;
  logic [5:0]  inst_addr;
  logic [15:0] input_inst;
  logic        start;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        busy;
  logic        halted;
  logic [5:0]  pc;
  logic [15:0] retired;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  risc_core_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .inst_wen   (inst_wen),
    .inst_addr  (inst_addr),
    .input_inst (input_inst),
    .start      (start),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] Halt = 16'hE000;
  localparam logic [15:0] Nop  = 16'hA000;

  function automatic logic [15:0] f_move(input int rd, input int imm);
    return {3'b010, 4'(rd), 9'(imm)};
  endfunction
  function automatic logic [15:0] f_load(input int rd, input int rs1, input int imm);
    return {3'b000, 4'(rd), 4'(rs1), 5'(imm)};
  endfunction
  function automatic logic [15:0] f_store(input int rs1, input int rs2);
    return {3'b001, 4'b0000, 4'(rs1), 4'(rs2), 1'b0};
  endfunction
  function automatic logic [15:0] f_mac(input int rd, input int rs1, input int rs2, input int f);
    return {3'b011, 4'(rd), 4'(rs1), 4'(rs2), 1'(f)};
  endfunction
  function automatic logic [15:0] f_bnz(input int r, input int off);
    return {3'b100, 4'(r), 9'(off)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_addr = 4'(r);
    #1;
    check(tag, 32'(dbg_data), exp);
  endtask

  task automatic load(input int a, input logic [15:0] w);
    inst_wen   = 1'b1;
    inst_addr  = 6'(a);
    input_inst = w;
    tick();
    inst_wen   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until halted rises; 100 is the give-up bound
  task automatic run_to_halt(input string tag, input int exp_edges);
    int n = 0;
    while (!halted && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    rst = 1'b1; inst_wen = 1'b0; inst_addr = '0; input_inst = '0; start = 1'b0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_retired", 32'(retired), 0);
    for (int i = 0; i < 16; i++) chk_reg($sformatf("rst_r%0d", i), i, 0);

    // Basic program: MOVE/MOVE/STORE/LOAD/HALT
    load(0, f_move(1, 5));
    load(1, f_move(2, 7));
    load(2, f_store(0, 2));
    load(3, f_load(3, 0, 0));
    load(4, Halt);
    go();
    check("p1_busy", 32'(busy), 1);
    repeat (5) tick();
    check("p1_not_halted_e5", 32'(halted), 0);
    tick();
    check("p1_halted_e6", 32'(halted), 1);
    check("p1_busy_off", 32'(busy), 0);
    check("p1_pc", 32'(pc), 5);
    check("p1_retired", 32'(retired), 4);
    chk_reg("p1_r1", 1, 5);
    chk_reg("p1_r2", 2, 7);
    chk_reg("p1_r3", 3, 7);

    // MAC chain, accumulator persistence and truncation
    load(0, f_move(1, 3));
    load(1, f_move(2, 4));
    load(2, f_mac(4, 1, 2, 0));
    load(3, f_mac(5, 1, 2, 1));
    load(4, f_mac(6, 1, 2, 1));
    load(5, f_mac(10, 0, 0, 1));
    load(6, f_move(1, 256));
    load(7, f_move(2, 256));
    load(8, f_mac(8, 1, 2, 0));
    load(9, f_move(11, 511));
    load(10, Halt);
    go();
    check("p2_retired_restart", 32'(retired), 0);
    check("p2_pc_restart", 32'(pc), 0);
    run_to_halt("p2_halt_edge", 12);
    chk_reg("p2_r4", 4, 12);
    chk_reg("p2_r5", 5, 24);
    chk_reg("p2_r6", 6, 36);
    chk_reg("p2_r10_acc", 10, 36);
    chk_reg("p2_r8_trunc", 8, 0);
    chk_reg("p2_r11_zext", 11, 16'h01FF);
    check("p2_retired", 32'(retired), 10);
    check("p2_pc", 32'(pc), 11);

    // Countdown loop through a dmem decrement table
    load(0, f_move(1, 1));
    load(1, f_move(2, 0));
    load(2, f_store(1, 2));
    load(3, f_move(1, 2));
    load(4, f_move(2, 1));
    load(5, f_store(1, 2));
    load(6, f_move(1, 3));
    load(7, f_move(2, 2));
    load(8, f_store(1, 2));
    load(9, f_move(2, 1));
    load(10, f_mac(7, 0, 0, 0));
    load(11, f_mac(7, 2, 2, 1));
    load(12, f_load(1, 1, 0));
    load(13, f_bnz(1, -2));
    load(14, f_mac(12, 2, 2, 1));
    load(15, Halt);
    go();
    run_to_halt("p3_halt_edge", 25);
    chk_reg("p3_r7_count", 7, 3);
    chk_reg("p3_r12_acc", 12, 4);
    chk_reg("p3_r1", 1, 0);
    check("p3_retired", 32'(retired), 21);
    check("p3_pc", 32'(pc), 16);

    // STORE right after HALT must not commit
    load(0, f_move(1, 5));
    load(1, f_move(2, 9));
    load(2, f_store(1, 2));
    load(3, f_move(2, 16'h77));
    load(4, Halt);
    load(5, f_store(1, 2));
    load(6, f_move(13, 1));
    go();
    run_to_halt("p4_halt_edge", 6);
    check("p4_pc", 32'(pc), 5);
    check("p4_retired", 32'(retired), 4);
    repeat (3) tick();
    check("p4_pc_frozen", 32'(pc), 5);
    check("p4_still_halted", 32'(halted), 1);
    // Rerun: imem[0] written on the same edge as start
    load(1, Halt);
    inst_wen = 1'b1; inst_addr = 6'd0; input_inst = f_load(14, 1, 0); start = 1'b1;
    tick();
    inst_wen = 1'b0; start = 1'b0;
    check("p4_rerun_pc", 32'(pc), 0);
    check("p4_rerun_retired", 32'(retired), 0);
    check("p4_rerun_busy", 32'(busy), 1);
    run_to_halt("p4_rerun_halt_edge", 3);
    chk_reg("p4_r14_dmem5", 14, 9);
    chk_reg("p4_r13", 13, 0);
    check("p4_rerun_retired_end", 32'(retired), 1);
    check("p4_rerun_pc_end", 32'(pc), 2);

    // Reset in the middle of a MAC loop; RUN ignores inst_wen and start
    load(0, f_move(1, 1));
    load(1, f_move(2, 2));
    load(2, f_mac(3, 2, 2, 1));
    load(3, f_bnz(1, -1));
    load(4, Halt);
    go();
    repeat (6) tick();
    check("p5_retired_e6", 32'(retired), 4);
    inst_wen = 1'b1; inst_addr = 6'd0; input_inst = Halt; start = 1'b1;
    tick();
    inst_wen = 1'b0; start = 1'b0;
    check("p5_start_ignored_busy", 32'(busy), 1);
    check("p5_start_ignored_ret", 32'(retired), 5);
    repeat (2) tick();
    check("p5_retired_e9", 32'(retired), 6);
    check("p5_pc_e9", 32'(pc), 3);
    #2 rst = 1'b1;
    #1;
    check("p5_async_busy", 32'(busy), 0);
    check("p5_async_halted", 32'(halted), 0);
    check("p5_async_pc", 32'(pc), 0);
    check("p5_async_retired", 32'(retired), 0);
    chk_reg("p5_async_r3", 3, 0);
    chk_reg("p5_async_r1", 1, 0);
    tick();
    rst = 1'b0;
    // imem[0] must still be MOVE r1,1
    load(1, f_move(1, 5));
    load(2, f_load(4, 0, 0));
    load(3, f_load(5, 1, 0));
    load(4, Halt);
    go();
    run_to_halt("p6_halt_edge", 6);
    chk_reg("p6_r1", 1, 5);
    chk_reg("p6_r4_dmem0", 4, 7);
    chk_reg("p6_r5_dmem5", 5, 9);
    chk_reg("p6_r3_cleared", 3, 0);
    check("p6_retired", 32'(retired), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_core_pipe.md
Name: risc_core_pipe

Overview:
- Parametrised two-stage successor of the single-cycle 16-bit LOAD/STORE/MOVE/MAC core.
- Contains a program counter, a loadable instruction memory, a fetch register (IF) and an execute/writeback stage (EX).
- Adds a start/halt run-control state machine, a conditional branch with a pipeline flush, a persistent MAC accumulator, a retired-instruction counter and a debug register read port.
- Top-level compute block of the design, fed by a testbench or loader through the instruction-write port.

Parameters:
- ISA_WIDTH, 16, instruction width; the field map below assumes 16.
- REG_DATA_WIDTH, 16, register, accumulator and data-memory word width.
- REG_ADDR_WIDTH, 4, register index width; 2^REG_ADDR_WIDTH registers.
- MEM_ADDR_WIDTH, 5, data-memory address width; 2^MEM_ADDR_WIDTH words.
- IMEM_ADDR_WIDTH, 6, instruction-memory address width; 2^IMEM_ADDR_WIDTH words.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- inst_wen  in  1  instruction-memory write enable.
- inst_addr  in  IMEM_ADDR_WIDTH  instruction write address.
- input_inst  in  ISA_WIDTH  instruction write data.
- start  in  1  run request, sampled in IDLE or HALTED.
- dbg_addr  in  REG_ADDR_WIDTH  debug register select.
- dbg_data  out  REG_DATA_WIDTH  regfile[dbg_addr], combinational.
- busy  out  1  state==RUN.
- halted  out  1  state==HALTED.
- pc  out  IMEM_ADDR_WIDTH  current fetch address.
- retired  out  CNT_WIDTH  count of committed non-HALT instructions.

Behaviour:
- Encoding: op=[15:13], rd=[12:9], rs1=[8:5], rs2=[4:1], funct=[0], imm5=[4:0], imm9=[8:0].
  - LOAD 000: rd <= dmem[(rs1 + zext imm5) mod 2^MEM_ADDR_WIDTH].
  - STORE 001: dmem[rs1 mod depth] <= rs2.
  - MOVE 010: rd <= zext imm9.
  - MAC 011, funct=0: acc <= rs1*rs2; rd <= rs1*rs2.
  - MAC 011, funct=1: acc <= acc + rs1*rs2; rd <= acc + rs1*rs2.
  - MAC arithmetic: products and sums are unsigned, truncated to REG_DATA_WIDTH.
  - BNZ 100: if reg[[12:9]] != 0, target = ir_pc + sext(imm9) mod 2^IMEM_ADDR_WIDTH.
  - HALT 111.
  - 101 and 110: NOP, but still counted in retired.
- Reset, asynchronous:
  - state=IDLE, pc=0, ir_valid=0, acc=0, all registers 0, retired=0.
  - busy=0, halted=0.
  - Instruction and data memories are not cleared.
- FSM:
  - IDLE, start=1 -> RUN; pc<=0, ir_valid<=0.
  - RUN, HALT committed in EX -> HALTED; pc frozen at the fetch address after HALT.
  - HALTED, start=1 -> RUN; pc<=0, retired<=0. Registers, acc and dmem are retained.
  - start is ignored while in RUN.
- Pipeline (RUN only):
  - Each edge: IR<=imem[pc], ir_pc<=pc, ir_valid<=1, pc<=pc+1 (wraps at depth).
  - EX executes IR when ir_valid=1.
  - Register and data-memory reads are combinational, writes happen at the edge, so there is no hazard stall.
  - First instruction commits at the 2nd edge after entering RUN.
- Branch taken:
  - pc<=target and ir_valid<=0 on the same edge; exactly 1 bubble.
  - A branch to self with a nonzero register loops forever.
  - A not-taken branch has no penalty.
- HALT in EX:
  - On that edge, ir_valid<=0.
  - The fetched successor is discarded and causes no side effects.
- inst_wen:
  - Writes imem[inst_addr] at the edge only when state != RUN.
  - Ignored in RUN.
  - A write and a start on the same edge in IDLE: the write completes, and the fetch of that address on the next edge sees the new data.
- retired:
  - Increments on each edge with ir_valid=1 and op != HALT.
  - Wraps at 2^CNT_WIDTH.
  - Flushed slots do not count.
- Reset mid-RUN aborts immediately: no partial writes, and dmem keeps already-committed stores.

Test Plan:
- Reset then IDLE: busy=0, halted=0, pc=0, retired=0, dbg_data=0 for all regs; inst_wen in IDLE loads code.
- Program MOVE r1,5; MOVE r2,7; STORE [r0]<-r2; LOAD r3,[r0+0]; HALT; start pulse -> r1=5, r2=7, r3=7, halted=1, retired=4, HALT commits on the 6th edge after start.
- MAC sequence r1=3, r2=4: MAC f0 r4 -> 12; MAC f1 r5 -> 24; MAC f1 r6 -> 36, acc=36. With r1=r2=0x0100, MAC f0 gives 0x0000 (truncation).
- Countdown loop:
  - Program: r1=3, r2=1; loop body adds 1 to r7 via MAC f1; decrement r1 via a preloaded dmem table; BNZ r1,-k.
  - Expected: loop body executes 3 times, with 1 bubble per taken branch.
  - Check: retired equals the committed count only; no flushed-slot side effects.
- Place a STORE immediately after HALT: dmem unchanged, pc frozen; then start again -> rerun from pc 0, retired restarts at 0.
- Assert rst mid-RUN during a MAC loop: all outputs return to reset values asynchronously, regs=0, dmem contents from earlier stores preserved; inst_wen during RUN is ignored.
